// File: rtl/oled_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the OLED frame refresh reader.
package oled_pkg;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_COL_HI    = 8'h10;

  typedef enum logic [3:0] {
    S_WAIT_INIT,
    S_START,
    S_CMD,
    S_CMD_WAIT,
    S_RD,
    S_RD_WAIT,
    S_DATA,
    S_DATA_WAIT,
    S_IDLE
  } oled_state_e;

  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int pages, input int cols);
    return bits_for(pages * cols);
  endfunction

  // Page-addressing command sequence: page select, column low nibble, column high nibble.
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [3:0] page,
                                          input logic [7:0] col_off);
    case (idx)
      2'd0:    return CMD_PAGE_BASE | {4'h0, page};
      2'd1:    return CMD_COL_LO | {4'h0, col_off[3:0]};
      default: return CMD_COL_HI | {4'h0, col_off[7:4]};
    endcase
  endfunction

endpackage

// File: rtl/oled_frame_refresh_if.sv
// Frame RAM read port and SPI byte-writer handshake of the OLED frame refresh reader.
interface oled_frame_refresh_if #(
  parameter int AW = 10
);
  logic          rden;
  logic [AW-1:0] rdaddress;
  logic [7:0]    ram_data;
  logic          ena_write;
  logic          oled_dc;
  logic [7:0]    data;
  logic          write_done;

  modport master (
    output rden, rdaddress, ena_write, oled_dc, data,
    input  ram_data, write_done
  );

  modport slave (
    input  rden, rdaddress, ena_write, oled_dc, data,
    output ram_data, write_done
  );
endinterface

// File: rtl/oled_refresh_timer.sv
// Idle-period counter: counts while enabled, clears on request, flags REFRESH_CYC-1.
module oled_refresh_timer
  import oled_pkg::*;
#(
  parameter int REFRESH_CYC = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int TW = bits_for(REFRESH_CYC);

  logic [TW-1:0] count_q;

  assign tc = en && (count_q == TW'(REFRESH_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en && !tc) begin
      count_q <= count_q + 1'b1;
    end
  end
endmodule

// File: rtl/oled_frame_refresh.sv
// Streams a page-organised frame buffer from RAM to the OLED SPI byte writer.
// Optional dirty-page skipping is enabled by defining OLED_DIRTY_SKIP_EN.
module oled_frame_refresh
  import oled_pkg::*;
#(
  parameter int PAGES       = 8,
  parameter int COLS        = 128,
  parameter int COL_OFFSET  = 0,
  parameter int REFRESH_CYC = 100_000,
  parameter int RD_LAT      = 1,
  parameter int PAGE_DESC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic               refresh_req,
  input  logic [PAGES-1:0]   dirty_set,
  oled_frame_refresh_if.master bus,
  output logic               busy,
  output logic               frame_done
);
  localparam int AW = addr_w(PAGES, COLS);
  localparam int SW = bits_for(PAGES);
  localparam int CW = bits_for(COLS);
  localparam logic [7:0] COL_OFF8 = 8'(COL_OFFSET);

  oled_state_e   state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [CW-1:0] col_q, col_d;
  logic [2:0]    lat_q, lat_d;
  logic          rden_q, rden_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ena_q, ena_d;
  logic          dc_q, dc_d;
  logic [7:0]    data_q, data_d;
  logic          fdone_q, fdone_d;
  logic          tmr_tc;
  logic [3:0]    page_num;
  logic          first_ok, next_ok;
  logic [SW-1:0] first_slot, next_slot;

  oled_refresh_timer #(.REFRESH_CYC(REFRESH_CYC)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q != S_IDLE),
    .en  (state_q == S_IDLE),
    .tc  (tmr_tc)
  );

  assign page_num = (PAGE_DESC != 0) ? 4'(PAGES - 1 - int'(slot_q)) : 4'(int'(slot_q));

`ifdef OLED_DIRTY_SKIP_EN
  logic [PAGES-1:0] dirty_q, dirty_clr;

  // A dirty_set landing on the same cycle as the clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) dirty_q <= '1;
    else     dirty_q <= (dirty_q & ~dirty_clr) | dirty_set;
  end

  always_comb begin
    first_ok   = 1'b0;
    first_slot = '0;
    next_ok    = 1'b0;
    next_slot  = '0;
    for (int unsigned i = 0; i < PAGES; i++) begin
      if (dirty_q[i] && !first_ok) begin
        first_ok   = 1'b1;
        first_slot = SW'(i);
      end
      if (dirty_q[i] && (i > 32'(slot_q)) && !next_ok) begin
        next_ok   = 1'b1;
        next_slot = SW'(i);
      end
    end
  end
`else
  logic unused_dirty_set;
  assign unused_dirty_set = ^dirty_set;
  assign first_ok   = 1'b1;
  assign first_slot = '0;
  assign next_ok    = (slot_q != SW'(PAGES - 1));
  assign next_slot  = slot_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cmd_d   = cmd_q;
    col_d   = col_q;
    lat_d   = lat_q;
    rden_d  = 1'b0;
    addr_d  = addr_q;
    ena_d   = 1'b0;
    dc_d    = dc_q;
    data_d  = data_q;
    fdone_d = 1'b0;
`ifdef OLED_DIRTY_SKIP_EN
    dirty_clr = '0;
`endif
    case (state_q)
      S_WAIT_INIT: if (init_done) state_d = S_START;
      S_START: begin
        if (first_ok) begin
          slot_d  = first_slot;
          cmd_d   = 2'd0;
          state_d = S_CMD;
        end else begin
          fdone_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        ena_d   = 1'b1;
        dc_d    = 1'b0;
        data_d  = cmd_byte(cmd_q, page_num, COL_OFF8);
        state_d = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (bus.write_done) begin
          if (cmd_q == 2'd2) begin
            col_d   = '0;
            state_d = S_RD;
          end else begin
            cmd_d   = cmd_q + 2'd1;
            state_d = S_CMD;
          end
        end
      end
      S_RD: begin
        rden_d  = 1'b1;
        addr_d  = AW'(int'(slot_q) * COLS + int'(col_q));
        lat_d   = '0;
        state_d = S_RD_WAIT;
      end
      // lat_q counts cycles since the rden pulse; capture exactly RD_LAT cycles later.
      S_RD_WAIT: begin
        if (lat_q == 3'(RD_LAT)) begin
          data_d  = bus.ram_data;
          dc_d    = 1'b1;
          state_d = S_DATA;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_DATA: begin
        ena_d   = 1'b1;
        state_d = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        if (bus.write_done) begin
          if (col_q == CW'(COLS - 1)) begin
`ifdef OLED_DIRTY_SKIP_EN
            dirty_clr[slot_q] = 1'b1;
`endif
            if (next_ok) begin
              slot_d  = next_slot;
              cmd_d   = 2'd0;
              state_d = S_CMD;
            end else begin
              fdone_d = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            col_d   = col_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_IDLE: if (tmr_tc || refresh_req) state_d = S_START;
      default: state_d = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT_INIT;
      slot_q  <= '0;
      cmd_q   <= '0;
      col_q   <= '0;
      lat_q   <= '0;
      rden_q  <= 1'b0;
      addr_q  <= '0;
      ena_q   <= 1'b0;
      dc_q    <= 1'b1;
      data_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cmd_q   <= cmd_d;
      col_q   <= col_d;
      lat_q   <= lat_d;
      rden_q  <= rden_d;
      addr_q  <= addr_d;
      ena_q   <= ena_d;
      dc_q    <= dc_d;
      data_q  <= data_d;
      fdone_q <= fdone_d;
    end
  end

  assign bus.rden      = rden_q;
  assign bus.rdaddress = addr_q;
  assign bus.ena_write = ena_q;
  assign bus.oled_dc   = dc_q;
  assign bus.data      = data_q;
  assign frame_done    = fdone_q;
  assign busy          = !(state_q inside {S_WAIT_INIT, S_IDLE}) || fdone_q;
endmodule
